// File: rtl/data_memory_pkg.sv
// Shared types and constants for the byte-addressed data memory.
package data_memory_pkg;

  localparam int unsigned MAX_RD_LATENCY = 4;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } rsp_stage_t;

  // Offset of the last byte touched by an access (access size minus one).
  function automatic logic [1:0] size_last(input size_e s);
    case (s)
      SIZE_B:  return 2'd0;
      SIZE_H:  return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_lane.sv
// Combinational byte-lane logic: store steering / byte enables and load
// extraction with sign or zero extension, for one 32-bit storage word.
module data_memory_lane
  import data_memory_pkg::*;
(
  input  size_e       i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata
);

  logic [4:0]  w_shift;
  logic [31:0] w_rshift;
  logic        w_sign_b;
  logic        w_sign_h;

  assign w_shift  = {i_offset, 3'b000};
  assign w_rshift = i_rword >> w_shift;
  assign w_sign_b = ~i_unsigned & w_rshift[7];
  assign w_sign_h = ~i_unsigned & w_rshift[15];

  always_comb begin
    o_be    = 4'b0000;
    o_wword = i_wdata << w_shift;
    o_rdata = '0;
    case (i_size)
      SIZE_B: begin
        o_be    = 4'b0001 << i_offset;
        o_rdata = {{24{w_sign_b}}, w_rshift[7:0]};
      end
      SIZE_H: begin
        o_be    = 4'b0011 << i_offset;
        o_rdata = {{16{w_sign_h}}, w_rshift[15:0]};
      end
      SIZE_W: begin
        o_be    = 4'b1111;
        o_rdata = w_rshift;
      end
      default: begin
        o_be    = 4'b0000;
        o_rdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory with valid/ready request and
// response channels and an RD_LATENCY-deep in-order response pipeline.
// Optional macro DATA_MEMORY_ALIGN_CHECK_EN turns misaligned half/word
// accesses into errors instead of aligning them down.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned WORDS  = DEPTH_BYTES / 4;
  localparam int unsigned WIDX_W = $clog2(WORDS);

  logic [3:0][7:0] r_mem [WORDS];
  rsp_stage_t      r_stg [RD_LATENCY];

  size_e             w_size;
  logic [ADDR_W:0]   w_last;
  logic              w_oor;
  logic              w_rsv;
  logic              w_misalign;
  logic              w_err;
  logic [1:0]        w_offset;
  logic [WIDX_W-1:0] w_widx;
  logic              w_stall;
  logic              w_accept;
  logic [3:0]        w_be;
  logic [31:0]       w_wword;
  logic [31:0]       w_lrdata;
  rsp_stage_t        w_new;

  assign w_size = size_e'(req_size);

  // Range check is done on the raw address, one bit wider so it cannot wrap.
  assign w_last = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, size_last(w_size)};
  assign w_oor  = (w_last >= (ADDR_W+1)'(DEPTH_BYTES));
  assign w_rsv  = (w_size == SIZE_RSV);

`ifdef DATA_MEMORY_ALIGN_CHECK_EN
  assign w_misalign = ((w_size == SIZE_H) && req_addr[0]) ||
                      ((w_size == SIZE_W) && (req_addr[1:0] != 2'b00));
  assign w_offset   = req_addr[1:0];
`else
  assign w_misalign = 1'b0;
  always_comb begin
    w_offset = req_addr[1:0];
    case (w_size)
      SIZE_H:  w_offset = {req_addr[1], 1'b0};
      SIZE_W:  w_offset = 2'b00;
      default: w_offset = req_addr[1:0];
    endcase
  end
`endif

  assign w_err  = w_rsv | w_oor | w_misalign;
  assign w_widx = req_addr[WIDX_W+1:2];

  assign w_stall   = r_stg[RD_LATENCY-1].valid & ~rsp_ready;
  assign req_ready = rst_n & ~w_stall;
  assign w_accept  = req_valid & req_ready;

  data_memory_lane u_lane (
    .i_size     (w_size),
    .i_unsigned (req_unsigned),
    .i_offset   (w_offset),
    .i_wdata    (req_wdata),
    .i_rword    (r_mem[w_widx]),
    .o_be       (w_be),
    .o_wword    (w_wword),
    .o_rdata    (w_lrdata)
  );

  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.err   = w_err;
    w_new.rdata = (!req_we && !w_err) ? w_lrdata : '0;
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_widx][b] <= w_wword[8*b +: 8];
      end
    end
  end

  // Idle slots carry a zero payload so outputs read 0 whenever not valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) r_stg[i] <= '0;
    end else if (!w_stall) begin
      r_stg[0] <= w_accept ? w_new : '0;
      for (int unsigned i = 1; i < RD_LATENCY; i++) r_stg[i] <= r_stg[i-1];
    end
  end

  assign rsp_valid = r_stg[RD_LATENCY-1].valid;
  assign rsp_rdata = r_stg[RD_LATENCY-1].rdata;
  assign rsp_err   = r_stg[RD_LATENCY-1].err;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: byte-array reference model with an
// expected-response queue, plus directed literal expectations.
module tb_data_memory;

  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests  = 0;
  int fails  = 0;
  int n_xfer = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          cnt;
  } exp_t;

  logic [7:0] mem [DEPTH];
  exp_t       q [$];

  always #5 clk = ~clk;

  data_memory #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .DEPTH_BYTES (DEPTH),
    .RD_LATENCY  (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int unsigned i);
    logic [7:0] b;
    b = i[7:0];
    return {b ^ 8'hA5, b + 8'h3C, ~b, b};
  endfunction

  // Reference behaviour: plain byte array, little-endian assembly, extension.
  function automatic void mdl(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er);
    int unsigned     n;
    longint unsigned last;
    logic [31:0]     ea;
    logic [31:0]     v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    rd = '0;
    er = 1'b0;
    if (n == 0) begin
      er = 1'b1;
      return;
    end
    last = {32'h0, a} + n - 1;
    if (last >= DEPTH) er = 1'b1;
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    if ((a % n) != 0) er = 1'b1;
    ea = a;
`else
    ea = a - (a % n);
`endif
    if (er) return;
    if (we) begin
      for (int unsigned k = 0; k < n; k++) mem[ea + k] = wd[8*k +: 8];
    end else begin
      v = '0;
      for (int unsigned k = 0; k < n; k++) v = v | ({24'h0, mem[ea + k]} << (8*k));
      if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rd = v;
    end
  endfunction

  // Cycle-by-cycle compare against the model, then advance the model.
  initial begin : compare
    logic        vis;
    logic [31:0] rd;
    logic        er;
    @(posedge clk);
    forever begin
      @(negedge clk);
      vis = (q.size() > 0) && (q[0].cnt == 0);
      chk("req_ready", {31'h0, req_ready}, {31'h0, rst_n && !(vis && !rsp_ready)});
      chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, vis});
      if (vis) begin
        chk("rsp_rdata", rsp_rdata, q[0].d);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, q[0].e});
      end
      if (!rst_n) begin
        q.delete();
      end else if (!(vis && !rsp_ready)) begin
        if (vis) begin
          void'(q.pop_front());
          n_xfer++;
        end
        foreach (q[i]) if (q[i].cnt > 0) q[i].cnt--;
        if (req_valid) begin
          mdl(req_we, req_size, req_unsigned, req_addr, req_wdata, rd, er);
          q.push_back('{d: rd, e: er, cnt: LAT - 1});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    bit acc;
    int b;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    acc = 1'b0;
    b = 0;
    while (!acc && b < 50) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      b++;
    end
    req_valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  // One request on an idle pipe; checks latency and the literal result.
  task automatic single(input string nm, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e);
    int lat;
    bit got;
    issue(we, sz, uns, a, wd);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) got = 1'b1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no response expected one within 20 cycles", nm);
    end else begin
      chk({nm, "_lat"}, lat, LAT);
      chk({nm, "_data"}, rsp_rdata, exp_d);
      chk({nm, "_err"}, {31'h0, rsp_err}, {31'h0, exp_e});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rel_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk); #1;

    for (int unsigned i = 0; i < DEPTH / 4; i++) issue(1'b1, 2'd2, 1'b0, i * 4, pat(i));
    repeat (LAT + 1) @(posedge clk);
    #1;

    single("st_w10",   1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB, 32'h0, 1'b0);
    single("ld_w10",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b0);
    single("ld_bs11",  1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0);
    single("ld_bu11",  1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'h000000AA, 1'b0);
    single("st_w20",   1'b1, 2'd2, 1'b0, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b0);
    single("st_h22",   1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF1234, 32'h0, 1'b0);
    single("ld_w20",   1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h1234FFFF, 1'b0);
    single("ld_oor",   1'b0, 2'd2, 1'b0, 32'h3FE, 32'h0, 32'h0, 1'b1);
    single("ld_rsv",   1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    single("st_oor",   1'b1, 2'd2, 1'b0, 32'h3FE, 32'hDEADBEEF, 32'h0, 1'b1);
    single("ld_w3fc",  1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 32'h5A3B00FF, 1'b0);
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    single("ld_w13",   1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    single("ld_hs11",  1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
`else
    single("ld_w13",   1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'h8899AABB, 1'b0);
    single("ld_hs11",  1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 32'hFFFFAABB, 1'b0);
`endif

    // Read-after-write: store byte then load the word on the next cycle.
    issue(1'b1, 2'd0, 1'b0, 32'h30, 32'hFFFFFF55);
    issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    repeat (LAT + 1) @(posedge clk);
    #1;
    single("ld_w30",   1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'hA948F355, 1'b0);

    // Back-to-back loads with a five-cycle consumer stall.
    base = n_xfer;
    fork
      begin
        issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h41, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 32'h42, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h46, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h47, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h48, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h4C, 32'h0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
        chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    for (int i = 0; i < 40 && n_xfer < base + 8; i++) @(posedge clk);
    #1;
    chk("stall_xfers", n_xfer - base, 32'd8);

    // Reset with two loads in flight; the earlier store must survive.
    single("st_w50",   1'b1, 2'd2, 1'b0, 32'h50, 32'hCAFEF00D, 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst2_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst2_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst2_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst2_req_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel2_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rel2_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk); #1;
    single("ld_w50",   1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 32'hCAFEF00D, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Parametrised, byte-addressed data memory that serves the execute/memory stage of the CPU datapath. It accepts byte, half-word and word loads and stores through a valid/ready request channel and returns one in-order response per request after a configurable read latency. It stores data little-endian, sign- or zero-extends loads, and flags out-of-range and illegal accesses instead of silently corrupting storage.

## Interface
- `ADDR_W`, 32: request address width.
- `DATA_W`, 32: data width; fixed at 32 in this generation.
- `DEPTH_BYTES`, 1024: storage size in bytes; must be a power of two and ≤ 2^ADDR_W.
- `RD_LATENCY`, 1: cycles from request accept to response valid; legal range 1..4.

Ports:
- `clk`  in  1  the single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  DATA_W  store data, right-aligned.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  DATA_W  load result, right-aligned and extended; 0 for stores and errors.
- `rsp_err`  out  1  access faulted.

## Operation
- A request is accepted on an edge where `req_valid && req_ready`.
- Storage is an array of `DEPTH_BYTES` bytes, little-endian; byte 0 is the LSB of a word.
- Store:
  - At the accept edge, write the low 1/2/4 bytes of `req_wdata` to `addr`..`addr+n-1`.
  - Leave all other bytes untouched.
  - Produce a response with `rsp_rdata`=0.
- Load:
  - Read the addressed bytes at the accept edge.
  - Extend to 32 bits per `req_unsigned`; a word load ignores `req_unsigned`.
- Error conditions:
  - `req_addr + n - 1 >= DEPTH_BYTES` (out of range) → `rsp_err`=1, no write, `rsp_rdata`=0.
  - `req_size`=11 → `rsp_err`=1, no write, `rsp_rdata`=0.
- Response pipeline:
  - `RD_LATENCY` stages, each a valid bit plus payload.
  - Responses leave in accept order.
- Stall:
  - Stall when the last stage is valid and `rsp_ready`=0.
  - During a stall every stage holds its contents and `req_ready`=0.
  - Otherwise `req_ready`=1.
- Read-after-write: a load accepted in the cycle after a store to the same bytes returns the stored data.
- Reset (`rst_n`=0 at an edge):
  - Clear all stage valids.
  - Outputs: `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0; `req_ready`=0 while `rst_n` is low.
  - In-flight responses are dropped. Stores already accepted remain in memory.
  - Memory contents are not reset.

## Timing
- Accept at edge N, no stall → `rsp_valid`=1 from edge N+`RD_LATENCY`.
- Throughput is one request per cycle when `rsp_ready` is held high.
- Each stall cycle delays all in-flight responses by one cycle.
- A response transfers on an edge with `rsp_valid && rsp_ready`. On that same edge the pipe advances and may accept a new request.
- `req_ready` is combinational from last-stage valid and `rsp_ready` only.
- First cycle after reset release: `req_ready`=1, `rsp_valid`=0.

## Configuration
- `DATA_MEMORY_ALIGN_CHECK_EN` defined:
  - A half with `addr[0]`=1, or a word with `addr[1:0]`≠0, is an error: `rsp_err`=1, no write, `rsp_rdata`=0.
- Not defined:
  - Misaligned halves and words are aligned down (low address bits forced to 0).
  - They complete normally with `rsp_err`=0.
- Out-of-range and reserved-size errors apply in both builds.

## Structure
- Package `data_memory_pkg`:
  - Size encodings `SIZE_B`, `SIZE_H`, `SIZE_W`, `SIZE_RSV`.
  - Response-stage struct: valid, rdata, err.
  - Constant `MAX_RD_LATENCY`=4.
- Sub-module `data_memory_lane`: combinational byte-lane logic.
  - Store-data byte steering and write-enable generation.
  - Load-data extraction and sign/zero extension.
- The top level holds storage, error checks, pipeline and handshake.

## Test plan
- Store word 0x8899AABB at 0x10, then load word, byte at 0x11 signed, and byte at 0x11 unsigned → 0x8899AABB, 0xFFFFFFAA, 0x000000AA.
- Store half 0x1234 at 0x22 over a word 0xFFFFFFFF at 0x20, then load word 0x20 → 0x1234FFFF.
- `RD_LATENCY`=3, back-to-back loads with `rsp_ready`=1 → responses at N+3, N+4, …, in order. Then hold `rsp_ready`=0 for 5 cycles → `req_ready`=0, responses held, none lost or duplicated.
- Accesses that fault:
  - Load word at 0x3FE with `DEPTH_BYTES`=1024 → `rsp_err`=1, `rsp_rdata`=0.
  - Reserved size → `rsp_err`=1.
  - A store at 0x3FE → `rsp_err`=1 and adjacent memory unchanged.
- Word load at 0x13 → `rsp_err`=1 with `DATA_MEMORY_ALIGN_CHECK_EN`; without it, returns the word at 0x10 with `rsp_err`=0.
- Assert `rst_n`=0 with 2 responses in flight:
  - Next cycle `rsp_valid`=0.
  - After release `req_ready`=1.
  - A previously accepted store is still readable.
